// File: rtl/alu_requester_if.sv
// Bundles the command, ALU and response signals of the ALU requester.
// master is the requester side; slave is the control path plus the ALU.
interface alu_requester_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [1:0]       cmd_op;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_opcode;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ready;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [1:0]       rsp_op;
   logic [1:0]       rsp_err;

   logic             busy;

   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_ready, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_op,
             rsp_err, busy
   );

   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_ready, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_op,
             rsp_err, busy
   );
endinterface

// File: rtl/alu_requester.sv
// Queues ALU commands and issues them one at a time; returns the result with a
// status code (00 ok, 01 divide-by-zero, 10 timeout) over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the head when one is present
// ISSUE  | operands registered to the ALU, one settle cycle, ready ignored
// WAIT   | waiting for alu_ready, bounded by the timeout down-counter
// RESP   | response held on rsp_* until the consumer accepts it
module alu_requester #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   alu_requester_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mem_a_q  [DEPTH];
   logic [WIDTH-1:0] mem_b_q  [DEPTH];
   logic [1:0]       mem_op_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;

   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [1:0]       alu_op_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic [1:0]       rsp_op_q, rsp_err_q;
   logic [TW-1:0]    tmr_q;

   logic             full, empty, cmd_ready_w, push, pop;
   logic [WIDTH-1:0] head_a, head_b;
   logic [1:0]       head_op;
   logic             head_dz;

   assign full        = (count_q == (PW+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign cmd_ready_w = !full && !rst;
   assign push        = bus.cmd_valid && cmd_ready_w;
   assign pop         = (state_q == S_IDLE) && !empty;

   assign head_a  = mem_a_q[rd_ptr_q];
   assign head_b  = mem_b_q[rd_ptr_q];
   assign head_op = mem_op_q[rd_ptr_q];
   assign head_dz = (head_op == 2'b11) && (head_b == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q]  <= bus.cmd_a;
         mem_b_q[wr_ptr_q]  <= bus.cmd_b;
         mem_op_q[wr_ptr_q] <= bus.cmd_op;
      end
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = head_dz ? S_RESP : S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (bus.alu_ready || tmr_q == '0) state_d = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Ready wins over an expiring timer on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_err_q    <= '0;
         tmr_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  rsp_op_q <= head_op;
                  if (head_dz) begin
                     rsp_result_q <= '0;
                     rsp_err_q    <= 2'b01;
                  end else begin
                     alu_a_q  <= head_a;
                     alu_b_q  <= head_b;
                     alu_op_q <= head_op;
                  end
               end
            end
            S_ISSUE: tmr_q <= TW'(TIMEOUT - 1);
            S_WAIT: begin
               if (bus.alu_ready) begin
                  rsp_result_q <= bus.alu_result;
                  rsp_err_q    <= 2'b00;
               end else if (tmr_q == '0) begin
                  rsp_result_q <= '0;
                  rsp_err_q    <= 2'b10;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.cmd_ready  = cmd_ready_w;
      bus.alu_a      = alu_a_q;
      bus.alu_b      = alu_b_q;
      bus.alu_opcode = alu_op_q;
      bus.rsp_valid  = (state_q == S_RESP);
      bus.rsp_result = rsp_result_q;
      bus.rsp_op     = rsp_op_q;
      bus.rsp_err    = rsp_err_q;
      bus.busy       = (state_q != S_IDLE) || !empty;
   end
endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester: a behavioural ALU with a controllable
// ready, stimulus tasks per scenario and hand-computed expected responses.
module tb_alu_requester;
   logic clk;
   logic rst;
   logic alu_rdy;
   int   checks;
   int   errors;
   int   cyc;

   alu_requester_if #(.WIDTH(32)) bus ();

   alu_requester #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_opcode)
         2'b00: bus.alu_result = bus.alu_a + bus.alu_b;
         2'b01: bus.alu_result = bus.alu_a - bus.alu_b;
         2'b10: bus.alu_result = bus.alu_a * bus.alu_b;
         2'b11: bus.alu_result = (bus.alu_b == 0) ? 32'd0 : bus.alu_a / bus.alu_b;
         default: bus.alu_result = '0;
      endcase
   end
   assign bus.alu_ready = alu_rdy;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      int n;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL push_stall: cmd_ready stayed %0b, required 1", bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input logic [31:0] er, input logic [1:0] eo,
                           input logic [1:0] ee, input string nm, output int t);
      int n;
      n = 0;
      t = 0;
      while (!bus.rsp_valid && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n == 200) begin
         errors++;
         $display("FAIL %s_valid: rsp_valid never rose, required 1", nm);
      end else begin
         t = cyc;
         if (bus.rsp_result !== er) begin
            errors++;
            $display("FAIL %s_result: got %0d, required %0d", nm, bus.rsp_result, er);
         end
         checks++;
         if (bus.rsp_op !== eo) begin
            errors++;
            $display("FAIL %s_op: got %0b, required %0b", nm, bus.rsp_op, eo);
         end
         checks++;
         if (bus.rsp_err !== ee) begin
            errors++;
            $display("FAIL %s_err: got %0b, required %0b", nm, bus.rsp_err, ee);
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %0b, required 0", bus.cmd_ready);
      end
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_opcode,
           bus.rsp_result, bus.rsp_op, bus.rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b busy=%0b a=%0d b=%0d op=%0b res=%0d rop=%0b err=%0b, required all 0",
                  bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_opcode,
                  bus.rsp_result, bus.rsp_op, bus.rsp_err);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %0b, required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_single_add();
      alu_rdy       = 1'b1;
      bus.rsp_ready = 1'b1;
      push(32'd10, 32'd20, 2'b00);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd10 || bus.alu_b !== 32'd20) begin
         errors++;
         $display("FAIL add_issue: valid=%0b a=%0d b=%0d, required 0 10 20",
                  bus.rsp_valid, bus.alu_a, bus.alu_b);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_early_valid: got %0b, required 0", bus.rsp_valid);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err} !== {1'b1, 32'd30, 2'b00, 2'b00}) begin
         errors++;
         $display("FAIL add_rsp: valid=%0b res=%0d op=%0b err=%0b, required 1 30 00 00",
                  bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL add_done: valid=%0b busy=%0b, required 0 0", bus.rsp_valid, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2, t3, t4, t5;
      alu_rdy       = 1'b1;
      bus.rsp_ready = 1'b0;
      push(32'd50, 32'd15, 2'b01);
      push(32'd7, 32'd8, 2'b10);
      push(32'd100, 32'd5, 2'b11);
      push(32'd10, 32'd20, 2'b00);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_three: got %0b, required 1", bus.cmd_ready);
      end
      push(32'd3, 32'd4, 2'b00);
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ready_full: got %0b, required 0", bus.cmd_ready);
      end
      bus.rsp_ready = 1'b1;
      wait_rsp(32'd35, 2'b01, 2'b00, "b2b_sub", t1);
      wait_rsp(32'd56, 2'b10, 2'b00, "b2b_mul", t2);
      wait_rsp(32'd20, 2'b11, 2'b00, "b2b_div", t3);
      wait_rsp(32'd30, 2'b00, 2'b00, "b2b_add", t4);
      wait_rsp(32'd7, 2'b00, 2'b00, "b2b_add2", t5);
      checks++;
      if (t3 - t2 !== 4 || t5 - t4 !== 4) begin
         errors++;
         $display("FAIL b2b_throughput: spacing %0d and %0d cycles, required 4", t3 - t2, t5 - t4);
      end
   endtask

   task automatic test_div_zero();
      int t;
      alu_rdy       = 1'b1;
      bus.rsp_ready = 1'b1;
      push(32'd100, 32'd0, 2'b11);
      push(32'd6, 32'd7, 2'b10);
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== {32'd3, 32'd4, 2'b00}) begin
         errors++;
         $display("FAIL dz_alu_hold: a=%0d b=%0d op=%0b, required 3 4 00",
                  bus.alu_a, bus.alu_b, bus.alu_opcode);
      end
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL dz_latency: rsp_valid %0b one edge after accept, required 1", bus.rsp_valid);
      end
      wait_rsp(32'd0, 2'b11, 2'b01, "dz", t);
      wait_rsp(32'd42, 2'b10, 2'b00, "dz_next", t);
   endtask

   task automatic test_timeout();
      int t;
      alu_rdy       = 1'b0;
      bus.rsp_ready = 1'b1;
      push(32'd1, 32'd2, 2'b00);
      repeat (17) tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL to_early: rsp_valid %0b before timeout, required 0", bus.rsp_valid);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err} !== {1'b1, 32'd0, 2'b00, 2'b10}) begin
         errors++;
         $display("FAIL to_rsp: valid=%0b res=%0d op=%0b err=%0b, required 1 0 00 10",
                  bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err);
      end
      tick();
      push(32'd5, 32'd6, 2'b00);
      tick();
      alu_rdy = 1'b1;
      tick();
      alu_rdy = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL issue_ready_sampled: rsp_valid %0b after ISSUE, required 0", bus.rsp_valid);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_no_ready: rsp_valid %0b, required 0", bus.rsp_valid);
      end
      alu_rdy = 1'b1;
      wait_rsp(32'd11, 2'b00, 2'b00, "after_to", t);
   endtask

   task automatic test_backpressure();
      int t;
      alu_rdy       = 1'b1;
      bus.rsp_ready = 1'b0;
      push(32'd9, 32'd3, 2'b01);
      push(32'd2, 32'd3, 2'b10);
      push(32'd4, 32'd4, 2'b00);
      push(32'd8, 32'd2, 2'b11);
      push(32'd1, 32'd1, 2'b01);
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: cmd_ready=%0b busy=%0b, required 0 1", bus.cmd_ready, bus.busy);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err} !== {1'b1, 32'd6, 2'b01, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%0b res=%0d op=%0b err=%0b, required 1 6 01 00",
                     i, bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err);
         end
      end
      bus.rsp_ready = 1'b1;
      wait_rsp(32'd6, 2'b01, 2'b00, "bp_a", t);
      wait_rsp(32'd6, 2'b10, 2'b00, "bp_b", t);
      wait_rsp(32'd8, 2'b00, 2'b00, "bp_c", t);
      wait_rsp(32'd4, 2'b11, 2'b00, "bp_d", t);
      wait_rsp(32'd0, 2'b01, 2'b00, "bp_e", t);
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: busy=%0b valid=%0b, required 0 0", bus.busy, bus.rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      alu_rdy       = 1'b0;
      bus.rsp_ready = 1'b1;
      push(32'd1, 32'd1, 2'b00);
      push(32'd2, 32'd2, 2'b00);
      push(32'd3, 32'd3, 2'b00);
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_ready: got %0b, required 0", bus.cmd_ready);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_opcode,
           bus.rsp_result, bus.rsp_op, bus.rsp_err} !== '0) begin
         errors++;
         $display("FAIL mid_rst_outputs: valid=%0b busy=%0b a=%0d b=%0d op=%0b res=%0d rop=%0b err=%0b, required all 0",
                  bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_opcode,
                  bus.rsp_result, bus.rsp_op, bus.rsp_err);
      end
      rst     = 1'b0;
      alu_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_quiet: cycle %0d valid=%0b busy=%0b ready=%0b, required 0 0 1",
                     i, bus.rsp_valid, bus.busy, bus.cmd_ready);
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      cyc           = 0;
      rst           = 1'b1;
      alu_rdy       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_op    = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single_add();
      test_back_to_back();
      test_div_zero();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
